obstacle_scheduler: RTL and testbench

//  Sequences the scrolling obstacle consumed by the obstacle renderer: owns its X position, gap bounds,

---
 rtl/obstacle_scheduler.sv | 120 ++++++++++++
 tb/tb_obstacle_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// Scrolling-obstacle sequencer: X/gap/score/state, one registered update per vsync rising edge, no backpressure.
// Optional OBST_SPEEDUP_EN: step grows by score[7:3], capped at 15 pixels per frame.
module obstacle_scheduler #(
  parameter int          HOR_PIXELS  = 800,
  parameter int          OBST_WIDTH  = 50,
  parameter int          GAP_TOP_MIN = 100,
  parameter int          GAP_H       = 200,
  parameter int          BIRD_X      = 200,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        start,
  input  logic        collision,
  input  logic [3:0]  speed,
  output logic [11:0] obstacle_xpos,
  output logic [9:0]  gap_top,
  output logic [9:0]  gap_bot,
  output logic [7:0]  score,
  output logic        score_pulse,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;

  localparam logic [11:0] X_RESET  = 12'(HOR_PIXELS);
  localparam logic [11:0] EDGE_OFS = 12'(OBST_WIDTH - 1);
  localparam logic [11:0] BIRD_COL = 12'(BIRD_X);
  localparam logic [9:0]  TOP_MIN  = 10'(GAP_TOP_MIN);
  localparam logic [9:0]  GAP_HGT  = 10'(GAP_H);

  state_t      st;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        vsync_d;
  logic        tick;
  logic [3:0]  step_base;
  logic [3:0]  step_eff;
  logic [11:0] x_step;
  logic        respawn;
  logic        scored;
  logic [9:0]  gap_new;

  assign tick      = vsync & ~vsync_d;
  assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
  assign gap_new   = TOP_MIN + {3'b000, lfsr[6:0]};
  assign state     = st;

`ifdef OBST_SPEEDUP_EN
  logic [5:0] step_sum;
  always_comb begin
    step_base = (speed == 4'd0) ? 4'd1 : speed;
    step_sum  = {2'b00, step_base} + {1'b0, score[7:3]};
    step_eff  = (step_sum > 6'd15) ? 4'd15 : step_sum[3:0];
  end
`else
  always_comb begin
    step_base = (speed == 4'd0) ? 4'd1 : speed;
    step_eff  = step_base;
  end
`endif

  // Scoring looks at the right edge crossing the player column on a plain move.
  always_comb begin
    respawn = obstacle_xpos < {8'd0, step_eff};
    x_step  = obstacle_xpos - {8'd0, step_eff};
    scored  = !respawn
              && ((obstacle_xpos + EDGE_OFS) >= BIRD_COL)
              && ((x_step + EDGE_OFS) < BIRD_COL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= IDLE;
      lfsr          <= LFSR_SEED;
      vsync_d       <= 1'b0;
      obstacle_xpos <= X_RESET;
      gap_top       <= TOP_MIN;
      gap_bot       <= TOP_MIN + GAP_HGT;
      score         <= 8'd0;
      score_pulse   <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      lfsr        <= lfsr_next;
      score_pulse <= 1'b0;
      case (st)
        IDLE, OVER: begin
          if (start) begin
            st            <= RUN;
            obstacle_xpos <= X_RESET;
            gap_top       <= gap_new;
            gap_bot       <= gap_new + GAP_HGT;
            score         <= 8'd0;
          end
        end
        RUN: begin
          // Collision wins over a same-cycle tick: the obstacle freezes where it is.
          if (collision) begin
            st <= OVER;
          end else if (tick) begin
            if (respawn) begin
              obstacle_xpos <= X_RESET;
              gap_top       <= gap_new;
              gap_bot       <= gap_new + GAP_HGT;
            end else begin
              obstacle_xpos <= x_step;
              if (scored) begin
                score_pulse <= 1'b1;
                if (score != 8'hFF) score <= score + 8'd1;
              end
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: cycle model of the game rules plus directed literal checks and random play.
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync = 1'b0;
  logic        start = 1'b0;
  logic        collision = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic [11:0] obstacle_xpos;
  logic [9:0]  gap_top;
  logic [9:0]  gap_bot;
  logic [7:0]  score;
  logic        score_pulse;
  logic [1:0]  state;

  obstacle_scheduler dut (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start), .collision(collision), .speed(speed),
    .obstacle_xpos(obstacle_xpos), .gap_top(gap_top), .gap_bot(gap_bot),
    .score(score), .score_pulse(score_pulse), .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference game state as plain integers.
  int          m_x, m_top, m_score, m_state, m_pulse, m_vd;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_step(input int sp, input int sc);
    int s;
    s = (sp == 0) ? 1 : sp;
`ifdef OBST_SPEEDUP_EN
    s = s + sc / 8;
    if (s > 15) s = 15;
`endif
    return s;
  endfunction

  initial forever begin
    bit tk;
    int s, nx;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_x = 800; m_top = 100; m_score = 0; m_pulse = 0; m_state = 0; m_vd = 0;
      m_lfsr = 16'hACE1;
    end else begin
      tk = vsync && (m_vd == 0);
      m_vd = vsync;
      m_pulse = 0;
      if (m_state == 0 || m_state == 2) begin
        if (start) begin
          m_state = 1; m_x = 800; m_top = 100 + int'(m_lfsr[6:0]); m_score = 0;
        end
      end else if (collision) begin
        m_state = 2;
      end else if (tk) begin
        s = eff_step(int'(speed), m_score);
        if (m_x < s) begin
          m_x = 800; m_top = 100 + int'(m_lfsr[6:0]);
        end else begin
          nx = m_x - s;
          if (m_x + 49 >= 200 && nx + 49 < 200) begin
            m_pulse = 1;
            if (m_score < 255) m_score++;
          end
          m_x = nx;
        end
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("xpos", int'(obstacle_xpos), m_x);
      check("gap_top", int'(gap_top), m_top);
      check("gap_bot", int'(gap_bot), m_top + 200);
      check("score", int'(score), m_score);
      check("score_pulse", int'(score_pulse), m_pulse);
      check("state", int'(state), m_state);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vpulse(input int n);
    repeat (n) begin
      vsync = 1'b1; cyc(1);
      vsync = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1);
    start = 1'b0;
  endtask

  initial begin
    int exp_step, base_x;
    #3 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;

    // Never started: vsync activity must not move anything.
    vpulse(10);
    check("idle_state", int'(state), 0);
    check("idle_xpos", int'(obstacle_xpos), 800);
    check("idle_score", int'(score), 0);
    check("idle_gap_top", int'(gap_top), 100);
    check("idle_gap_bot", int'(gap_bot), 300);

    speed = 4'd4;
    pulse_start();
    check("start_state", int'(state), 1);
    vpulse(5);
    check("run_xpos_780", int'(obstacle_xpos), 780);
    check("gap_range", int'(gap_top >= 10'd100 && gap_top <= 10'd227), 1);
    check("gap_height", int'(gap_bot) - int'(gap_top), 200);

    // 780 -> 160 at 10 px/frame, then the crossing tick scores.
    speed = 4'd10;
    vpulse(62);
    check("x_160", int'(obstacle_xpos), 160);
    check("score_pre", int'(score), 0);
    vsync = 1'b1; cyc(1);
    check("x_150", int'(obstacle_xpos), 150);
    check("score_one", int'(score), 1);
    check("pulse_high", int'(score_pulse), 1);
    vsync = 1'b0; cyc(1);
    check("pulse_low", int'(score_pulse), 0);

    vpulse(15);
    check("x_zero", int'(obstacle_xpos), 0);
    speed = 4'd0;
    vpulse(1);
    check("respawn_x", int'(obstacle_xpos), 800);
    check("respawn_state", int'(state), 1);

    // Collision coinciding with a tick freezes the obstacle.
    speed = 4'd10;
    vpulse(40);
    check("x_400", int'(obstacle_xpos), 400);
    vsync = 1'b1; collision = 1'b1; cyc(1);
    check("over_state", int'(state), 2);
    check("over_xpos", int'(obstacle_xpos), 400);
    collision = 1'b0; vsync = 1'b0; cyc(1);
    vpulse(5);
    check("over_hold_x", int'(obstacle_xpos), 400);
    check("over_hold_score", int'(score), 1);
    pulse_start();
    check("restart_state", int'(state), 1);
    check("restart_x", int'(obstacle_xpos), 800);
    check("restart_score", int'(score), 0);

    // Asynchronous reset mid-run while vsync is high.
    speed = 4'd4;
    vpulse(3);
    vsync = 1'b1; cyc(1);
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_x", int'(obstacle_xpos), 800);
    check("arst_score", int'(score), 0);
    check("arst_gap_top", int'(gap_top), 100);
    cyc(1);
    rst = 1'b0;
    cyc(3);
    check("post_rst_idle", int'(state), 0);
    vsync = 1'b0; cyc(1);
    pulse_start();
    check("post_rst_start_x", int'(obstacle_xpos), 800);
    vsync = 1'b1; cyc(1);
    check("post_rst_tick_x", int'(obstacle_xpos), 796);
    vsync = 1'b0; cyc(1);

    // Random play against the model.
    repeat (3000) begin
      speed     = 4'($urandom_range(0, 15));
      vsync     = 1'($urandom_range(0, 1));
      collision = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    collision = 1'b0; start = 1'b0; vsync = 1'b0;
    cyc(1);

    // Fast frames at top speed drive the score into saturation.
    pulse_start();
    speed = 4'd15;
    repeat (30000) begin
      vsync = ~vsync; cyc(1);
    end
    vsync = 1'b0; cyc(1);
    check("score_sat", int'(score), 255);

`ifdef OBST_SPEEDUP_EN
    exp_step = 15;
`else
    exp_step = 4;
`endif
    speed = 4'd4;
    for (int i = 0; i < 4 && m_x < 15; i++) vpulse(1);
    base_x = m_x;
    vpulse(1);
    check("step_at_255", base_x - int'(obstacle_xpos), exp_step);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
